// File: rtl/mcm_pkg.sv
// Shared MCM definitions: result width, BCD digit count and formatter state encoding.
package mcm_pkg;

    localparam int MCM_RES_W      = 27;
    localparam int MCM_BCD_DIGITS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/mcm_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 ahead of the shift.
module mcm_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    // Largest corrected value is 12, so 4 bits never carry out.
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/mcm_bcd_out.sv
// MCM result formatter: captures a binary result, converts it to BCD one bit per
// cycle, then streams the decimal digits MSD-first over a valid/ready handshake.
module mcm_bcd_out
    import mcm_pkg::*;
#(
    parameter int WIDTH    = MCM_RES_W,
    parameter int DIGITS   = MCM_BCD_DIGITS,
    parameter bit SUPPRESS = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN,
    input  logic             DIG_READY,
    input  logic             CLR_OVR,
    output logic             DIG_VALID,
    output logic [3:0]       DIG,
    output logic             DIG_LAST,
    output logic             BUSY,
    output logic             OVERRUN
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_state_e             state_q, state_d;
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic [DIGITS-1:0][3:0] bcd_q, bcd_d, bcd_adj, bcd_step;
    logic [4*DIGITS-1:0]    adj_flat;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d, lead;
    logic                   ovr_q, ovr_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        mcm_add3 u_add3 (
            .d_i (bcd_q[g]),
            .q_o (bcd_adj[g])
        );
    end

    // One double-dabble step: corrected digits shift left, taking the binary MSB.
    assign adj_flat = bcd_adj;
    assign bcd_step = (adj_flat << 1) | {{(4*DIGITS-1){1'b0}}, bin_q[WIDTH-1]};

    // Highest non-zero digit of the final BCD value; 0 when the value is zero.
    always_comb begin
        lead = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_step[i] != 4'd0) lead = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;

        if (CLR_OVR) ovr_d = 1'b0;
        if (IN_VALID && state_q != IDLE) ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    bin_d   = IN;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = SEND;
                    idx_d   = SUPPRESS ? lead : IDX_W'(DIGITS - 1);
                end
            end
            SEND: begin
                if (DIG_READY) begin
                    if (idx_q == '0) state_d = IDLE;
                    else             idx_d   = idx_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
        end
    end

    // Outputs decode registered state only, so DIG_READY never reaches them combinationally.
    assign DIG_VALID = (state_q == SEND);
    assign DIG       = DIG_VALID ? bcd_q[idx_q] : 4'd0;
    assign DIG_LAST  = DIG_VALID && (idx_q == '0);
    assign BUSY      = (state_q != IDLE);
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_mcm_bcd_out.sv
// Self-checking bench for mcm_bcd_out: directed scenarios plus randomized values and
// ready patterns, checked against a divide-by-ten digit model.
module tb_mcm_bcd_out;
    import mcm_pkg::*;

    localparam int W = MCM_RES_W;
    localparam int D = MCM_BCD_DIGITS;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         iv = 1'b0, iv0 = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [W-1:0] din = '0;
    logic         dv, dl, busy, ovr;
    logic [3:0]   dg;
    logic         dv0, dl0, busy0, ovr0;
    logic [3:0]   dg0;

    int n_checks = 0, n_err = 0;
    int cyc = 0, t0 = 0;
    int exp_q[$], got_d[$], got_l[$], got_c[$];
    int unstable, timeout;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcm_bcd_out #(.WIDTH(W), .DIGITS(D), .SUPPRESS(1'b1)) dut (
        .CLK(clk), .RESET(rst_n), .IN_VALID(iv), .IN(din), .DIG_READY(rdy), .CLR_OVR(clr),
        .DIG_VALID(dv), .DIG(dg), .DIG_LAST(dl), .BUSY(busy), .OVERRUN(ovr)
    );

    mcm_bcd_out #(.WIDTH(W), .DIGITS(D), .SUPPRESS(1'b0)) dut0 (
        .CLK(clk), .RESET(rst_n), .IN_VALID(iv0), .IN(din), .DIG_READY(rdy), .CLR_OVR(clr),
        .DIG_VALID(dv0), .DIG(dg0), .DIG_LAST(dl0), .BUSY(busy0), .OVERRUN(ovr0)
    );

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // Reference: decimal digits by repeated division, leading zeros optionally dropped.
    task automatic build_exp(input longint v, input bit sup);
        longint p;
        bit     started;
        int     dgt;
        exp_q.delete();
        p = 1;
        for (int k = 1; k < D; k++) p = p * 10;
        started = !sup;
        for (int k = 0; k < D; k++) begin
            dgt = int'((v / p) % 10);
            if (dgt != 0 || k == D - 1) started = 1'b1;
            if (started) exp_q.push_back(dgt);
            p = p / 10;
        end
    endtask

    // One-cycle result strobe; returns in cycle 1 with t0 marking cycle 0.
    task automatic start(input logic [W-1:0] v, input bit sel);
        t0  = cyc;
        din = v;
        if (sel) iv0 = 1'b1; else iv = 1'b1;
        tick;
        iv = 1'b0; iv0 = 1'b0;
    endtask

    // Records accepted digits until the DIG_LAST handshake; mode 0 ready=1, 1 pattern, 2 random.
    task automatic collect(input bit sel, input int mode, input int budget);
        int  prev_d, prev_l, vc;
        bit  pend, done, v;
        got_d.delete(); got_l.delete(); got_c.delete();
        unstable = 0; timeout = 1; pend = 0; done = 0; vc = 0; prev_d = 0; prev_l = 0;
        for (int i = 0; i < budget && !done; i++) begin
            v = sel ? dv0 : dv;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = v && (vc % 5 == 1 || vc % 5 == 4);
                default: rdy = 1'(($urandom % 3) != 0);
            endcase
            @(negedge clk);
            v = sel ? dv0 : dv;
            if (v) begin
                vc++;
                if (pend && (prev_d != int'(sel ? dg0 : dg) || prev_l != int'(sel ? dl0 : dl)))
                    unstable++;
                prev_d = int'(sel ? dg0 : dg);
                prev_l = int'(sel ? dl0 : dl);
                if (rdy) begin
                    got_d.push_back(prev_d); got_l.push_back(prev_l); got_c.push_back(cyc - t0);
                    pend = 0;
                    if (prev_l != 0) begin done = 1; timeout = 0; end
                end else pend = 1;
            end else if (pend) unstable++;
            tick;
        end
        rdy = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        @(negedge clk);
        n_checks++;
        if ({dv, dg, dl, busy, ovr} !== 8'd0) begin
            n_err++; $display("FAIL reset_outputs got=%b exp=0", {dv, dg, dl, busy, ovr});
        end
        n_checks++;
        if ({dv0, dg0, dl0, busy0, ovr0} !== 8'd0) begin
            n_err++; $display("FAIL reset_outputs_nosup got=%b exp=0", {dv0, dg0, dl0, busy0, ovr0});
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_zero;
        start('0, 0);
        collect(0, 0, 60);
        n_checks++;
        if (timeout != 0 || got_d.size() != 1 || got_d[0] != 0 || got_l[0] != 1) begin
            n_err++; $display("FAIL zero_digit got=%p last=%p exp single 0 with last", got_d, got_l);
        end
        n_checks++;
        if (got_c.size() < 1 || got_c[0] != W + 1) begin
            n_err++; $display("FAIL zero_latency got=%p exp=%0d", got_c, W + 1);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dv !== 1'b0) begin
            n_err++; $display("FAIL zero_busy_after got busy=%b valid=%b exp 0 0", busy, dv);
        end
    endtask

    task automatic test_max;
        bit ok;
        build_exp(134217727, 1);
        start(W'(134217727), 0);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || dv !== 1'b0) begin
            n_err++; $display("FAIL max_busy_conv got busy=%b valid=%b exp 1 0", busy, dv);
        end
        tick;
        collect(0, 0, 60);
        ok = (timeout == 0) && (got_d.size() == exp_q.size());
        foreach (exp_q[k])
            if (ok && (got_d[k] != exp_q[k] || got_l[k] != int'(k == exp_q.size() - 1) ||
                       got_c[k] != W + 1 + k)) ok = 0;
        n_checks++;
        if (!ok) begin
            n_err++; $display("FAIL max_digits got=%p cyc=%p exp=%p from cycle %0d", got_d, got_c, exp_q, W + 1);
        end
    endtask

    task automatic test_stall;
        bit ok;
        build_exp(1050, 1);
        start(W'(1050), 0);
        collect(0, 1, 120);
        ok = (timeout == 0) && (got_d.size() == exp_q.size());
        foreach (exp_q[k])
            if (ok && (got_d[k] != exp_q[k] || got_l[k] != int'(k == exp_q.size() - 1))) ok = 0;
        n_checks++;
        if (!ok) begin
            n_err++; $display("FAIL stall_digits got=%p exp=%p", got_d, exp_q);
        end
        n_checks++;
        if (unstable != 0) begin
            n_err++; $display("FAIL stall_hold got=%0d changes while stalled exp=0", unstable);
        end
    endtask

    task automatic test_overrun;
        bit ok;
        bit found;
        int extra;
        build_exp(500, 1);
        start(W'(500), 0);
        tick; tick; tick;
        din = W'(7); iv = 1'b1;
        tick;
        iv = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ovr !== 1'b1) begin
            n_err++; $display("FAIL overrun_set got=%b exp=1", ovr);
        end
        tick;
        collect(0, 0, 60);
        ok = (timeout == 0) && (got_d.size() == exp_q.size());
        foreach (exp_q[k])
            if (ok && (got_d[k] != exp_q[k] || got_c[k] != W + 1 + k)) ok = 0;
        n_checks++;
        if (!ok) begin
            n_err++; $display("FAIL overrun_untouched got=%p cyc=%p exp=%p", got_d, got_c, exp_q);
        end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ovr !== 1'b0) begin
            n_err++; $display("FAIL overrun_clear got=%b exp=0", ovr);
        end
        tick;
        // Set and clear in the same cycle: set must win.
        start(W'(9), 0);
        tick;
        din = W'(3); iv = 1'b1; clr = 1'b1;
        tick;
        iv = 1'b0; clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ovr !== 1'b1) begin
            n_err++; $display("FAIL overrun_set_wins got=%b exp=1", ovr);
        end
        tick;
        collect(0, 0, 60);
        n_checks++;
        if (timeout != 0 || got_d.size() != 1 || got_d[0] != 9) begin
            n_err++; $display("FAIL overrun_set_wins_digits got=%p exp=9", got_d);
        end
        clr = 1'b1; tick; clr = 1'b0;
        // New result on the final handshake is dropped, not started.
        start(W'(21), 0);
        rdy = 1'b1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (dl) begin din = W'(5); iv = 1'b1; found = 1; end
            tick;
            iv = 1'b0;
        end
        rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!found || busy !== 1'b0 || ovr !== 1'b1) begin
            n_err++; $display("FAIL overrun_last_hs got found=%0d busy=%b ovr=%b exp 1 0 1", found, busy, ovr);
        end
        extra = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (dv || busy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_err++; $display("FAIL overrun_last_hs_dropped got=%0d active cycles exp=0", extra);
        end
        clr = 1'b1; tick; clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit found;
        bit ok;
        start(W'(98765), 0);
        tick;
        din = W'(7); iv = 1'b1;
        tick;
        iv = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (dv) found = 1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (!found || {dv, dg, dl, busy, ovr} !== 8'd0) begin
            n_err++; $display("FAIL reset_mid_async got found=%0d outs=%b exp 1 and 0", found, {dv, dg, dl, busy, ovr});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick;
        @(negedge clk);
        n_checks++;
        if (dv !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_residual got valid=%b busy=%b exp 0 0", dv, busy);
        end
        tick;
        build_exp(42, 1);
        start(W'(42), 0);
        collect(0, 0, 60);
        ok = (timeout == 0) && (got_d.size() == exp_q.size());
        foreach (exp_q[k])
            if (ok && (got_d[k] != exp_q[k] || got_c[k] != W + 1 + k)) ok = 0;
        n_checks++;
        if (!ok) begin
            n_err++; $display("FAIL reset_mid_after got=%p cyc=%p exp=%p", got_d, got_c, exp_q);
        end
    endtask

    task automatic test_nosup;
        bit ok;
        build_exp(42, 0);
        start(W'(42), 1);
        collect(1, 0, 80);
        ok = (timeout == 0) && (got_d.size() == D) && (got_d.size() == exp_q.size());
        foreach (exp_q[k])
            if (ok && (got_d[k] != exp_q[k] || got_l[k] != int'(k == D - 1))) ok = 0;
        n_checks++;
        if (!ok) begin
            n_err++; $display("FAIL nosup_digits got=%p last=%p exp=%p", got_d, got_l, exp_q);
        end
    endtask

    task automatic test_random;
        int unsigned bnd[8];
        int unsigned v;
        bit sel, ok;
        bnd = '{9, 10, 99, 100, 99999999, 100000000, 1, 134217727};
        for (int it = 0; it < 24; it++) begin
            v   = (it < 8) ? bnd[it] : $urandom_range(0, (1 << W) - 1);
            sel = (it % 3 == 2);
            build_exp(longint'(v), !sel);
            start(W'(v), sel);
            collect(sel, 2, 200);
            ok = (timeout == 0) && (got_d.size() == exp_q.size()) && (unstable == 0);
            foreach (exp_q[k])
                if (ok && (got_d[k] != exp_q[k] || got_l[k] != int'(k == exp_q.size() - 1))) ok = 0;
            n_checks++;
            if (!ok) begin
                n_err++; $display("FAIL random_%0d v=%0d sup=%0d got=%p exp=%p unstable=%0d", it, v, !sel, got_d, exp_q, unstable);
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_zero;
        test_max;
        test_stall;
        test_overrun;
        test_reset_mid;
        test_nosup;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
